// File: rtl/box_pkg.sv
// Shared types and constants for the box sprite blocks.
// State encoding, default colours and coordinate width.
package box_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [11:0] C_OB_RGB  = 12'hF00;
    localparam logic [11:0] C_PL_RGB  = 12'h0F0;
    localparam logic [11:0] C_HIT_RGB = 12'hFFF;
    localparam logic [11:0] C_BG_RGB  = 12'h000;
    localparam logic [11:0] C_BLANK   = 12'h000;

endpackage

// File: rtl/box_inside.sv
// Strict point-in-box test; edge pixels count as outside.
// An inverted or empty box (x1>=x2 or y1>=y2) never matches.
module box_inside
    import box_pkg::*;
(
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_x2,
    input  logic [COORD_W-1:0] i_y1,
    input  logic [COORD_W-1:0] i_y2,
    output logic               o_in
);

    logic w_in_x;
    logic w_in_y;

    // Both axes must lie strictly between the edges.
    always_comb begin
        w_in_x = (i_x > i_x1) && (i_x < i_x2);
        w_in_y = (i_y > i_y1) && (i_y < i_y2);
        o_in   = w_in_x && w_in_y;
    end

endmodule

// File: rtl/box_collide_render.sv
// Pixel colouring, overlap capture and lives/hold control
// for the obstacle and player boxes.
module box_collide_render
    import box_pkg::*;
#(
    parameter int          LIVES       = 3,
    parameter int          HOLD_FRAMES = 60,
    parameter logic [11:0] OB_RGB      = C_OB_RGB,
    parameter logic [11:0] PL_RGB      = C_PL_RGB,
    parameter logic [11:0] HIT_RGB     = C_HIT_RGB,
    parameter logic [11:0] BG_RGB      = C_BG_RGB
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_active,
    input  logic               i_frame_end,
    input  logic [COORD_W-1:0] i_ob_x1,
    input  logic [COORD_W-1:0] i_ob_x2,
    input  logic [COORD_W-1:0] i_ob_y1,
    input  logic [COORD_W-1:0] i_ob_y2,
    input  logic [COORD_W-1:0] i_pl_x1,
    input  logic [COORD_W-1:0] i_pl_x2,
    input  logic [COORD_W-1:0] i_pl_y1,
    input  logic [COORD_W-1:0] i_pl_y2,
    input  logic               i_restart,
    output logic [11:0]        o_rgb,
    output logic               o_animate,
    output logic [3:0]         o_lives,
    output logic               o_hit,
    output logic [1:0]         o_state
);

    localparam logic [3:0] LIVES_L = 4'(LIVES);
    localparam logic [7:0] HOLD_L  = 8'(HOLD_FRAMES - 1);

    state_t      r_state;
    state_t      w_state_n;
    logic [3:0]  r_lives;
    logic [3:0]  w_lives_n;
    logic [7:0]  r_hold;
    logic [7:0]  w_hold_n;
    logic        r_coll;
    logic        w_coll_n;
    logic        r_hit;
    logic        w_hit_n;
    logic [11:0] r_rgb;
    logic [11:0] w_pix;
    logic        w_in_ob;
    logic        w_in_pl;
    logic        w_overlap;
    logic        w_hit_seen;

    box_inside u_in_ob (
        .i_x  (i_x),
        .i_y  (i_y),
        .i_x1 (i_ob_x1),
        .i_x2 (i_ob_x2),
        .i_y1 (i_ob_y1),
        .i_y2 (i_ob_y2),
        .o_in (w_in_ob)
    );

    box_inside u_in_pl (
        .i_x  (i_x),
        .i_y  (i_y),
        .i_x1 (i_pl_x1),
        .i_x2 (i_pl_x2),
        .i_y1 (i_pl_y1),
        .i_y2 (i_pl_y2),
        .o_in (w_in_pl)
    );

    // Colour priority: blanking, overlap, obstacle, player, background.
    always_comb begin
        w_pix = BG_RGB;
        if (!i_active)
            w_pix = C_BLANK;
        else if (w_in_ob && w_in_pl)
            w_pix = HIT_RGB;
        else if (w_in_ob)
            w_pix = OB_RGB;
        else if (w_in_pl)
            w_pix = PL_RGB;
    end

    // A visible overlap pixel only matters while the game is running.
    always_comb begin
        w_overlap  = i_pix_stb && i_active && w_in_ob && w_in_pl;
        w_hit_seen = r_coll || w_overlap;
    end

    // Overlap latch for the current frame; frame end and restart clear it.
    always_comb begin
        w_coll_n = r_coll;
        if (i_restart || i_frame_end)
            w_coll_n = 1'b0;
        else if (w_overlap && (r_state == ST_RUN))
            w_coll_n = 1'b1;
    end

    // Next-state logic: restart wins, otherwise act on frame end.
    always_comb begin
        w_state_n = r_state;
        w_lives_n = r_lives;
        w_hold_n  = r_hold;
        w_hit_n   = 1'b0;
        if (i_restart) begin
            w_state_n = ST_RUN;
            w_lives_n = LIVES_L;
            w_hold_n  = 8'd0;
        end else if (i_frame_end) begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_hit_seen) begin
                        w_hit_n   = 1'b1;
                        w_lives_n = r_lives - 4'd1;
                        if (r_lives == 4'd1) begin
                            w_state_n = ST_OVER;
                        end else begin
                            w_state_n = ST_HIT;
                            w_hold_n  = HOLD_L;
                        end
                    end
                end
                ST_HIT: begin
                    if (r_hold == 8'd0)
                        w_state_n = ST_RUN;
                    else
                        w_hold_n = r_hold - 8'd1;
                end
                ST_OVER: begin
                    w_state_n = ST_OVER;
                end
                default: begin
                    w_state_n = ST_RUN;
                end
            endcase
        end
    end

    // Game state, lives, hold counter and hit pulse registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_lives <= LIVES_L;
            r_hold  <= 8'd0;
            r_coll  <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_lives <= w_lives_n;
            r_hold  <= w_hold_n;
            r_coll  <= w_coll_n;
            r_hit   <= w_hit_n;
        end
    end

    // Pixel colour register, updated once per pixel strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rgb <= 12'h000;
        else if (i_pix_stb)
            r_rgb <= w_pix;
    end

    assign o_rgb     = r_rgb;
    assign o_animate = (r_state == ST_RUN);
    assign o_lives   = r_lives;
    assign o_hit     = r_hit;
    assign o_state   = r_state;

endmodule

// File: tb/tb_box_collide_render.sv
// Directed and randomized checks of box_collide_render
// against a frame-level behavioural model.
module tb_box_collide_render;

    localparam int LIVES = 3;
    localparam int HOLD  = 60;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_pix_stb = 1'b0;
    logic [11:0] i_x = '0;
    logic [11:0] i_y = '0;
    logic        i_active = 1'b0;
    logic        i_frame_end = 1'b0;
    logic [11:0] i_ob_x1 = '0;
    logic [11:0] i_ob_x2 = '0;
    logic [11:0] i_ob_y1 = '0;
    logic [11:0] i_ob_y2 = '0;
    logic [11:0] i_pl_x1 = '0;
    logic [11:0] i_pl_x2 = '0;
    logic [11:0] i_pl_y1 = '0;
    logic [11:0] i_pl_y2 = '0;
    logic        i_restart = 1'b0;
    logic [11:0] o_rgb;
    logic        o_animate;
    logic [3:0]  o_lives;
    logic        o_hit;
    logic [1:0]  o_state;

    int tests = 0;
    int fails = 0;

    // model: mode 0=RUN 1=HIT 2=OVER
    int          m_mode;
    int          m_lives;
    int          m_left;
    bit          m_pending;
    bit          m_hit;
    logic [11:0] m_rgb;

    box_collide_render dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pix_stb   (i_pix_stb),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_active    (i_active),
        .i_frame_end (i_frame_end),
        .i_ob_x1     (i_ob_x1),
        .i_ob_x2     (i_ob_x2),
        .i_ob_y1     (i_ob_y1),
        .i_ob_y2     (i_ob_y2),
        .i_pl_x1     (i_pl_x1),
        .i_pl_x2     (i_pl_x2),
        .i_pl_y1     (i_pl_y1),
        .i_pl_y2     (i_pl_y2),
        .i_restart   (i_restart),
        .o_rgb       (o_rgb),
        .o_animate   (o_animate),
        .o_lives     (o_lives),
        .o_hit       (o_hit),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    function automatic bit inbox(int x, int y, int x1, int x2,
                                 int y1, int y2);
        return (x > x1) && (x < x2) && (y > y1) && (y < y2);
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_lives   = LIVES;
        m_left    = 0;
        m_pending = 0;
        m_hit     = 0;
        m_rgb     = 12'h000;
    endtask

    task automatic check(string tag);
        tests++;
        assert (o_rgb === m_rgb) else begin
            fails++;
            $error("FAIL %s rgb got %h exp %h", tag, o_rgb, m_rgb);
        end
        tests++;
        assert (o_lives === 4'(m_lives)) else begin
            fails++;
            $error("FAIL %s lives got %0d exp %0d", tag, o_lives, m_lives);
        end
        tests++;
        assert (o_state === 2'(m_mode)) else begin
            fails++;
            $error("FAIL %s state got %0d exp %0d", tag, o_state, m_mode);
        end
        tests++;
        assert (o_animate === (m_mode == 0)) else begin
            fails++;
            $error("FAIL %s animate got %b exp %b", tag, o_animate,
                   m_mode == 0);
        end
        tests++;
        assert (o_hit === m_hit) else begin
            fails++;
            $error("FAIL %s hit got %b exp %b", tag, o_hit, m_hit);
        end
    endtask

    // Drive one clock with the given pulses, advance the model, check.
    task automatic go(bit stb, bit fe, bit rs, string tag);
        bit io, ip, ov;
        i_pix_stb   = stb;
        i_frame_end = fe;
        i_restart   = rs;
        io = inbox(i_x, i_y, i_ob_x1, i_ob_x2, i_ob_y1, i_ob_y2);
        ip = inbox(i_x, i_y, i_pl_x1, i_pl_x2, i_pl_y1, i_pl_y2);
        ov = stb && i_active && io && ip;
        if (stb) begin
            if (!i_active)     m_rgb = 12'h000;
            else if (io && ip) m_rgb = 12'hFFF;
            else if (io)       m_rgb = 12'hF00;
            else if (ip)       m_rgb = 12'h0F0;
            else               m_rgb = 12'h000;
        end
        m_hit = 0;
        if (rs) begin
            m_mode    = 0;
            m_lives   = LIVES;
            m_left    = 0;
            m_pending = 0;
        end else if (fe) begin
            if (m_mode == 0 && (m_pending || ov)) begin
                m_lives--;
                m_hit = 1;
                if (m_lives == 0) m_mode = 2;
                else begin
                    m_mode = 1;
                    m_left = HOLD;
                end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            m_pending = 0;
        end else if (ov && m_mode == 0) begin
            m_pending = 1;
        end
        @(posedge i_clk);
        #1;
        check(tag);
    endtask

    task automatic set_pix(int x, int y, bit act);
        i_x      = 12'(x);
        i_y      = 12'(y);
        i_active = act;
    endtask

    task automatic hit_and_hold(string tag);
        set_pix(150, 150, 1);
        go(1, 0, 0, {tag, "_ov"});
        go(0, 1, 0, {tag, "_fe"});
        if (m_mode == 1) begin
            for (int k = 0; k < HOLD; k++) begin
                go(1, 0, 0, {tag, "_hov"});
                go(1, 1, 0, {tag, "_hold"});
            end
        end
    endtask

    initial begin
        model_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset");
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("post_reset");

        // obstacle alone, player far away
        i_ob_x1 = 80;  i_ob_x2 = 120; i_ob_y1 = 80;  i_ob_y2 = 120;
        i_pl_x1 = 500; i_pl_x2 = 600; i_pl_y1 = 500; i_pl_y2 = 600;
        set_pix(100, 100, 1);
        go(1, 0, 0, "ob_pix");
        set_pix(0, 0, 1);
        go(0, 0, 0, "rgb_hold");
        set_pix(80, 100, 1);
        go(1, 0, 0, "ob_edge");
        set_pix(100, 100, 1);
        go(1, 0, 0, "ob_pix2");
        set_pix(100, 100, 0);
        go(1, 0, 0, "inactive");
        set_pix(550, 550, 1);
        go(1, 0, 0, "pl_pix");

        // overlapping boxes at (150,150)
        i_ob_x1 = 80;  i_ob_x2 = 200; i_ob_y1 = 80;  i_ob_y2 = 200;
        i_pl_x1 = 140; i_pl_x2 = 300; i_pl_y1 = 140; i_pl_y2 = 300;
        hit_and_hold("hit1");
        go(0, 0, 0, "run_again");
        hit_and_hold("hit2");
        hit_and_hold("hit3");
        set_pix(150, 150, 1);
        for (int k = 0; k < 3; k++) go(1, 1, 0, "over_fe");

        // restart beats frame end with overlap pending
        go(1, 0, 0, "over_ov");
        go(1, 1, 1, "restart_fe");
        go(0, 0, 0, "after_rs");

        // overlap on the frame-end cycle itself
        go(0, 1, 0, "clean_fe");
        go(1, 1, 0, "same_cycle");
        go(0, 0, 0, "same_after");
        go(1, 1, 1, "restart2");

        // async reset mid-frame discards a pending hit
        go(1, 0, 0, "pre_rst_ov");
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        i_pix_stb = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        set_pix(10, 10, 1);
        go(0, 1, 0, "rst_fe");

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (n % 50 == 0) begin
                i_ob_x1 = 12'($urandom_range(0, 120));
                i_ob_x2 = 12'($urandom_range(40, 200));
                i_ob_y1 = 12'($urandom_range(0, 120));
                i_ob_y2 = 12'($urandom_range(40, 200));
                i_pl_x1 = 12'($urandom_range(0, 120));
                i_pl_x2 = 12'($urandom_range(40, 200));
                i_pl_y1 = 12'($urandom_range(0, 120));
                i_pl_y2 = 12'($urandom_range(40, 200));
            end
            set_pix($urandom_range(0, 200), $urandom_range(0, 200),
                    $urandom_range(0, 7) != 0);
            go($urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 255) == 0,
               "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/box_collide_render.md
Name: box_collide_render

Overview:
- Consumer end of the obstacle/player box-edge interface.
- Takes the VGA scan position plus the edge outputs of the moving obstacle and player boxes (x1/x2/y1/y2, 12-bit each). Produces the registered pixel colour and detects pixel-accurate overlap, counting each frame with overlap as one hit.
- Runs a lives/hold state machine whose o_animate output drives the animate enable of the box animators.
- Sits between the VGA timing generator, the box animators and the top-level colour pins.

Parameters:
- LIVES, 3, lives loaded at reset/restart (1..15)
- HOLD_FRAMES, 60, frames animation is frozen after a hit (1..255)
- OB_RGB, 12'hF00, obstacle colour
- PL_RGB, 12'h0F0, player colour
- HIT_RGB, 12'hFFF, colour of overlapping pixels
- BG_RGB, 12'h000, background colour

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  reset
- i_pix_stb  in  1  pixel strobe, one pixel per strobe
- i_x  in  12  current scan column
- i_y  in  12  current scan row
- i_active  in  1  scan position is in the visible area
- i_frame_end  in  1  single-cycle pulse at end of frame, same cycle as the animation strobe
- i_ob_x1, i_ob_x2, i_ob_y1, i_ob_y2  in  12 each  obstacle edges
- i_pl_x1, i_pl_x2, i_pl_y1, i_pl_y2  in  12 each  player edges
- i_restart  in  1  single-cycle request to start a new game
- o_rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- o_animate  out  1  high only in RUN
- o_lives  out  4  remaining lives
- o_hit  out  1  one-cycle pulse when a hit is registered
- o_state  out  2  RUN=0, HIT=1, OVER=2

Interface decision: one clock, i_clk; reset i_rst is asynchronous and active-high.

Behaviour:
- Reset (async, active-high) sets:
  - state=RUN, o_lives=LIVES, hold_cnt=0, coll_flag=0
  - o_rgb=0, o_hit=0; o_animate=1 as soon as reset deasserts.
- Inside test (unsigned, strict):
  - in_ob = (i_x>i_ob_x1)&(i_x<i_ob_x2)&(i_y>i_ob_y1)&(i_y<i_ob_y2); in_pl likewise.
  - Edge pixels are outside. If x1>=x2 or y1>=y2, the box never matches.
- Pixel path:
  - On each clock with i_pix_stb, o_rgb updates. Priority: !i_active->12'h000; in_ob&in_pl->HIT_RGB; in_ob->OB_RGB; in_pl->PL_RGB; else BG_RGB.
  - o_rgb holds between strobes. Latency is exactly 1 clock after the strobe cycle.
  - Colouring is state-independent.
- Collision capture:
  - coll_flag sets on any clock with i_pix_stb & i_active & in_ob & in_pl while state=RUN.
  - Cleared on every i_frame_end, on restart and on reset.
  - An overlap pixel on the same cycle as i_frame_end counts toward the ending frame.
- State machine; all transitions happen on i_frame_end unless stated otherwise:
  - RUN, hit seen (coll_flag or same-cycle overlap): o_lives-=1 and o_hit=1 for that one cycle. New lives==0 -> OVER; else -> HIT with hold_cnt=HOLD_FRAMES-1.
  - RUN, no hit: stay in RUN.
  - HIT: on frame_end, if hold_cnt==0 -> RUN, else hold_cnt-=1. The freeze therefore lasts exactly HOLD_FRAMES frame_end pulses. Overlaps are ignored.
  - OVER: remain until i_restart. o_lives stays 0 and never underflows.
- i_restart, in any state and on any cycle: state=RUN, o_lives=LIVES, coll_flag=0, hold_cnt=0.
  - Restart beats a simultaneous i_frame_end: no decrement and no o_hit.
- o_animate = (state==RUN), decoded from the state register with no extra delay.
- o_hit is otherwise 0.
- An async reset mid-frame discards coll_flag and any pending hit.

Decomposition:
- Shared package box_pkg holds:
  - state encoding constants ST_RUN/ST_HIT/ST_OVER
  - 12-bit colour constants
  - coordinate width constant (12), also used by the box animators.
- One natural sub-module, box_inside: a combinational strict inside test of one point against one box. It is instantiated twice here and reused by later sprite blocks.

Test Plan:
- Reset, then drive i_x=100,i_y=100,i_active=1 with the obstacle at 80..120/80..120, player far away and one strobe -> o_rgb=12'hF00 one clock after the strobe; i_x=80 (edge) -> BG_RGB; i_active=0 -> 12'h000.
- Boxes overlapping at (150,150), with a strobe at that pixel in RUN and then i_frame_end -> o_hit pulses once, o_lives 3->2, o_state=HIT, o_animate=0.
- HOLD_FRAMES=60 after a hit -> o_animate stays 0 through 59 frame_end pulses and returns to 1 (RUN) on the 60th. Overlap strobes during HIT produce no o_hit.
- Three frames with a hit, each followed by the hold -> o_lives 3,2,1,0, o_state=OVER after the third, o_animate=0; further frame_ends keep o_lives=0.
- OVER, then assert i_restart on the same cycle as i_frame_end with an overlap pending -> state RUN, o_lives=3, o_hit=0.
- Overlap pixel on the same cycle as i_frame_end with no earlier overlap -> hit is counted for that frame. Assert i_rst asynchronously mid-frame after an overlap -> outputs reset immediately and no hit occurs at the next frame_end.
